pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64: maximum MD_WAIT cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port id_rs  input  5  rs field of the instruction in ID.
REQ-006 SHALL have port id_rt  input  5  rt field of the instruction in ID.
REQ-007 SHALL have port id_uses_rt  input  1  the ID instruction reads rt.
REQ-008 SHALL have port ex_mem_read  input  1  the EX instruction is a load.
REQ-009 SHALL have port ex_rt  input  5  load destination register in EX.
REQ-010 SHALL have port ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-011 SHALL have port md_start  input  1  mult/div instruction present in EX.
REQ-012 SHALL have port md_done  input  1  multiplier/divider result ready.
REQ-013 SHALL have port imem_ready  input  1  instruction memory fetch valid.
REQ-014 SHALL have port pc_en  output  1  PC register update enable.
REQ-015 SHALL have port if_id_en  output  1  IF/ID register load enable.
REQ-016 SHALL have port id_ex_en  output  1  ID/EX register load enable.
REQ-017 SHALL have port if_id_flush  output  1  zero IF/ID contents (NOP).
REQ-018 SHALL have port id_ex_flush  output  1  zero ID/EX contents (bubble).
REQ-019 SHALL have port stall_cnt  output  CNT_W  saturating count of cycles with pc_en=0.
REQ-020 SHALL have port flush_cnt  output  CNT_W  saturating count of branch flushes.
REQ-021 SHALL have port md_err  output  1  sticky flag: MD_TIMEOUT expired.

Function
REQ-022 SHALL implement FSM states RUN and MD_WAIT; the enable/flush outputs SHALL be combinational from state and inputs; counters and md_err SHALL be registered.
REQ-023 Default in RUN: pc_en=if_id_en=id_ex_en=1, both flushes=0.
REQ-024 Priority in RUN, highest first: branch flush, md stall, load-use stall, fetch stall.
REQ-025 Branch: ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1, all enables=1; flush_cnt+1; any concurrent load-use or fetch stall is suppressed.
REQ-026 MD stall: md_start=1 and md_done=0 -> pc_en=if_id_en=id_ex_en=0; next state MD_WAIT; md_start and md_done both 1 -> no stall, stay RUN.
REQ-027 Load-use: ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)) -> pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1; lasts exactly one cycle.
REQ-028 Fetch stall: imem_ready=0 -> pc_en=0, if_id_flush=1, if_id_en=1.
REQ-029 MD_WAIT: all enables=0, flushes=0; ex_branch_taken, load-use, and imem_ready SHALL be ignored; internal wait counter increments each cycle.
REQ-030 MD_WAIT exit: md_done=1 -> outputs as MD_WAIT this cycle, RUN next; wait counter cleared.
REQ-031 Timeout: wait counter reaching MD_TIMEOUT-1 with md_done=0 -> md_err set (sticky), return to RUN next cycle.
REQ-032 stall_cnt SHALL increment in every cycle with pc_en=0; both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-033 While reset=1: pc_en=if_id_en=id_ex_en=0, if_id_flush=id_ex_flush=1.
REQ-034 On a clock edge with reset=1: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, md_err=0.
REQ-035 Reset SHALL override all other inputs, including in MD_WAIT.
REQ-036 md_err SHALL be cleared only by reset.

Structure
REQ-037 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MD_WAIT), the MD_TIMEOUT default, and the REG_ZERO constant (5'd0).
REQ-038 Saturating counters SHALL use one sub-module, sat_counter (parameter width, inc, clear), instantiated twice.

Verification
REQ-039 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
REQ-040 Load with ex_rt=0, id_rs=0 -> no stall; id_uses_rt=0, id_rt=ex_rt=7, id_rs=3 -> no stall.
REQ-041 Branch and load-use in the same cycle -> both flushes=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
REQ-042 md_start=1, md_done after 10 cycles -> enables=0 for 11 cycles, RUN afterwards; md_err=0.
REQ-043 md_start=1, md_done never asserted, MD_TIMEOUT=8 -> md_err=1 after 8 cycles, back in RUN; md_err held until reset.
REQ-044 reset asserted in MD_WAIT cycle 3 -> reset values (REQ-033) that cycle; RUN with counters=0 after the edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t        : controller FSM states (RUN, MD_WAIT)
//   MD_TIMEOUT_DEF : default multiply/divide wait limit in cycles
//   REG_ZERO       : architectural zero register index; never a hazard source
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam int MD_TIMEOUT_DEF = 64;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk   : clock, rising edge
//   clear : synchronous clear, wins over inc
//   inc   : add one this cycle unless already at all-ones
//   count : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage in-order pipeline.
// Resolves taken branches, multiply/divide waits, load-use hazards and
// instruction-fetch stalls into register enables and flushes, and keeps
// saturating counts of stall cycles and branch flushes.
//   clk, reset       : clock and synchronous active-high reset
//   id_rs, id_rt     : source registers of the instruction in ID
//   id_uses_rt       : ID instruction actually reads rt
//   ex_mem_read      : EX instruction is a load; ex_rt is its destination
//   ex_branch_taken  : branch/jump resolved taken in EX
//   md_start/md_done : mult/div issue in EX and result-ready handshake
//   imem_ready       : instruction fetch valid this cycle
//   pc_en, if_id_en, id_ex_en       : register update enables
//   if_id_flush, id_ex_flush        : insert NOP / bubble
//   stall_cnt, flush_cnt            : saturating performance counters
//   md_err           : sticky mult/div timeout flag, cleared only by reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             md_err
);

  // Wait counter only has to reach MD_TIMEOUT-1.
  localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              md_timeout;
  logic              flush_inc;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // md_done wins over an expiring timeout in the same cycle.
  assign md_timeout = (state == MD_WAIT) && !md_done && (wait_cnt == WAIT_LAST);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_nxt   = state;
    flush_inc   = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            // Wrong-path instructions in IF and ID are squashed; the redirect
            // proceeds, so no other hazard may hold the PC this cycle.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (md_start && !md_done) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            state_nxt = MD_WAIT;
          end else if (load_use) begin
            // Hold IF and ID, push a bubble into EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            // Hold PC, feed a NOP into ID while the fetch is outstanding.
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          if (md_done || md_timeout) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      md_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == MD_WAIT) && (state_nxt == MD_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (md_timeout) begin
        md_err <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// dut uses default parameters; dut8 uses MD_TIMEOUT=8 and 4-bit counters so
// timeout and counter saturation are reachable in a few cycles.
// Output bundles are {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, md_start, md_done, imem_ready;

  logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, md_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en8, if_id_en8, id_ex_en8, if_id_flush8, id_ex_flush8, md_err8;
  logic [3:0]  stall_cnt8, flush_cnt8;

  logic [4:0] outs, outs8;
  assign outs  = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush};
  assign outs8 = {pc_en8, if_id_en8, id_ex_en8, if_id_flush8, id_ex_flush8};

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .md_start(md_start), .md_done(md_done), .imem_ready(imem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .md_err(md_err)
  );

  pipe_hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .md_start(md_start), .md_done(md_done), .imem_ready(imem_ready),
    .pc_en(pc_en8), .if_id_en(if_id_en8), .id_ex_en(id_ex_en8),
    .if_id_flush(if_id_flush8), .id_ex_flush(id_ex_flush8),
    .stall_cnt(stall_cnt8), .flush_cnt(flush_cnt8), .md_err(md_err8)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
    ex_mem_read = 1'b0; ex_rt = 5'd3; ex_branch_taken = 1'b0;
    md_start = 1'b0; md_done = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic do_reset();
    step(); drive_idle(); reset = 1'b1;
    step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #3;
    total_cnt++; if (outs !== 5'b00011) $display("FAIL reset_outs got=%b exp=00011", outs); else pass_cnt++;
    step();
    #3;
    total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd0) $display("FAIL reset_flush got=%0d exp=0", flush_cnt); else pass_cnt++;
    total_cnt++; if (md_err !== 1'b0) $display("FAIL reset_md_err got=%b exp=0", md_err); else pass_cnt++;
    step(); reset = 1'b0;
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL run_default got=%b exp=11100", outs); else pass_cnt++;
  endtask

  task automatic test_load_use();
    step(); drive_idle(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #3;
    total_cnt++; if (outs !== 5'b00101) $display("FAIL load_use_rs got=%b exp=00101", outs); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL load_use_release got=%b exp=11100", outs); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd1) $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_cnt); else pass_cnt++;
    step(); drive_idle(); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd4;
    #3;
    total_cnt++; if (outs !== 5'b00101) $display("FAIL load_use_rt got=%b exp=00101", outs); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (stall_cnt !== 16'd2) $display("FAIL load_use_rt_cnt got=%0d exp=2", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_no_hazard();
    step(); drive_idle(); ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL zero_reg_load got=%b exp=11100", outs); else pass_cnt++;
    step(); drive_idle(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL rt_unused got=%b exp=11100", outs); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (stall_cnt !== 16'd2) $display("FAIL no_hazard_cnt got=%0d exp=2", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_fetch_stall();
    step(); drive_idle(); imem_ready = 1'b0;
    #3;
    total_cnt++; if (outs !== 5'b01110) $display("FAIL fetch_stall got=%b exp=01110", outs); else pass_cnt++;
    step(); drive_idle(); imem_ready = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd1;
    #3;
    total_cnt++; if (outs !== 5'b00101) $display("FAIL load_use_over_fetch got=%b exp=00101", outs); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (stall_cnt !== 16'd4) $display("FAIL fetch_stall_cnt got=%0d exp=4", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_branch();
    step(); drive_idle(); ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd1; imem_ready = 1'b0;
    #3;
    total_cnt++; if (outs !== 5'b11111) $display("FAIL branch_over_stalls got=%b exp=11111", outs); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (flush_cnt !== 16'd1) $display("FAIL branch_flush_cnt got=%0d exp=1", flush_cnt); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd4) $display("FAIL branch_stall_cnt got=%0d exp=4", stall_cnt); else pass_cnt++;
    step(); drive_idle(); ex_branch_taken = 1'b1; md_start = 1'b1;
    #3;
    total_cnt++; if (outs !== 5'b11111) $display("FAIL branch_over_md got=%b exp=11111", outs); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL branch_md_stays_run got=%b exp=11100", outs); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd2) $display("FAIL branch_flush_cnt2 got=%0d exp=2", flush_cnt); else pass_cnt++;
  endtask

  task automatic test_md_done();
    int bad_cycles;
    bad_cycles = 0;
    step(); drive_idle(); md_start = 1'b1;
    #3;
    if (outs !== 5'b00000) bad_cycles++;
    // MD_WAIT must ignore branch, load-use and fetch stalls.
    for (int i = 1; i <= 9; i++) begin
      step(); drive_idle(); ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd1; imem_ready = 1'b0;
      #3;
      if (outs !== 5'b00000) bad_cycles++;
    end
    step(); drive_idle(); md_done = 1'b1;
    #3;
    if (outs !== 5'b00000) bad_cycles++;
    total_cnt++; if (bad_cycles !== 0) $display("FAIL md_wait_outs bad_cycles=%0d exp=0", bad_cycles); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL md_exit_run got=%b exp=11100", outs); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd15) $display("FAIL md_stall_cnt got=%0d exp=15", stall_cnt); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd2) $display("FAIL md_flush_ignored got=%0d exp=2", flush_cnt); else pass_cnt++;
    total_cnt++; if (md_err !== 1'b0) $display("FAIL md_done_no_err got=%b exp=0", md_err); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int bad_cycles;
    bad_cycles = 0;
    do_reset();
    step(); drive_idle(); md_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(); drive_idle();
      #3;
      if ((outs8 !== 5'b00000) || (md_err8 !== 1'b0)) bad_cycles++;
    end
    total_cnt++; if (bad_cycles !== 0) $display("FAIL timeout_wait bad_cycles=%0d exp=0", bad_cycles); else pass_cnt++;
    step(); drive_idle();
    #3;
    total_cnt++; if (md_err8 !== 1'b1) $display("FAIL timeout_md_err got=%b exp=1", md_err8); else pass_cnt++;
    total_cnt++; if (outs8 !== 5'b11100) $display("FAIL timeout_back_run got=%b exp=11100", outs8); else pass_cnt++;
    total_cnt++; if (stall_cnt8 !== 4'd9) $display("FAIL timeout_stall_cnt got=%0d exp=9", stall_cnt8); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      step(); drive_idle();
    end
    for (int k = 0; k < 10; k++) begin
      step(); drive_idle(); imem_ready = 1'b0;
    end
    step(); drive_idle();
    #3;
    total_cnt++; if (md_err8 !== 1'b1) $display("FAIL md_err_sticky got=%b exp=1", md_err8); else pass_cnt++;
    total_cnt++; if (stall_cnt8 !== 4'hF) $display("FAIL stall_saturate got=%0d exp=15", stall_cnt8); else pass_cnt++;
  endtask

  task automatic test_reset_in_md_wait();
    do_reset();
    #3;
    total_cnt++; if (md_err8 !== 1'b0) $display("FAIL md_err_reset_clear got=%b exp=0", md_err8); else pass_cnt++;
    step(); drive_idle(); md_start = 1'b1;
    step(); drive_idle();
    step(); drive_idle();
    step(); drive_idle(); reset = 1'b1;
    #3;
    total_cnt++; if (outs !== 5'b00011) $display("FAIL reset_in_md_outs got=%b exp=00011", outs); else pass_cnt++;
    step(); reset = 1'b0;
    #3;
    total_cnt++; if (outs !== 5'b11100) $display("FAIL reset_in_md_run got=%b exp=11100", outs); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL reset_in_md_stall got=%0d exp=0", stall_cnt); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd0) $display("FAIL reset_in_md_flush got=%0d exp=0", flush_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_fetch_stall();
    test_branch();
    test_md_done();
    test_timeout();
    test_reset_in_md_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
